eth_field_sequencer: RTL and testbench
======================================

// Module: eth_field_sequencer
// PURPOSE
//  Byte-wide RX field sequencer for the 1G MAC. Tracks a GMII-style byte stream
//  from the PHY shim through preamble/SFD, dst MAC, src MAC, EtherType and payload+FCS.
//  Drives the master side of eth_fields_if so downstream extractors know which field
//  the current byte belongs to. Reports one end-of-frame status per frame.
// PARAMETERS
//  MAX_PREAMBLE_BYTES  7     max 0x55 bytes accepted before SFD
//  MIN_PAYLOAD_FCS     50    min payload+FCS bytes (46 + 4); fewer -> runt
//  MAX_FRAME_BYTES     1518  max bytes dst..FCS inclusive; more -> giant
// PORTS
//  clk           in   1    core clock
//  rst           in   1    asynchronous, active-high reset
//  rx_valid      in   1    rx_data/rx_last valid this cycle
//  rx_data       in   8    current byte
//  rx_last       in   1    current byte is last of frame (qualified by rx_valid)
//  fields        mst  if   eth_fields_if.master; per-byte field flags
//  frame_done    out  1    1-cycle pulse: frame ended, status bits below valid
//  frame_ok      out  1    frame passed all checks (valid with frame_done)
//  err_preamble  out  1    bad preamble byte or > MAX_PREAMBLE_BYTES
//  err_trunc     out  1    rx_last before first payload byte
//  err_runt      out  1    payload+FCS bytes < MIN_PAYLOAD_FCS
//  err_giant     out  1    dst..FCS bytes > MAX_FRAME_BYTES
// BEHAVIOUR
//  - States: IDLE, PREAMBLE, DST_MAC, SRC_MAC, ETHER_TYPE, PAYLOAD, DROP.
//    Advance only on rx_valid=1. rx_valid=0 holds all state and counters.
//  - Field flags are combinational, zero latency, and describe the current byte.
//    All flags are 0 when rx_valid=0. At most one flag is high per cycle.
//    is_preamble_or_sfd: IDLE with 0x55, or PREAMBLE with 0x55/0xD5.
//    is_dst_mac / is_src_mac / is_ether_type / is_payload_or_fcs: the matching state.
//  - IDLE: 0x55 -> PREAMBLE, pre_cnt=1. Any other byte -> DROP (silent).
//  - PREAMBLE: 0xD5 -> DST_MAC, fld_cnt=0.
//    0x55 with pre_cnt<MAX -> stay, pre_cnt++.
//    0x55 with pre_cnt=MAX, or any other byte -> DROP, error latched = err_preamble.
//  - DST_MAC 6 bytes, then SRC_MAC 6 bytes, then ETHER_TYPE 2 bytes.
//    fld_cnt (3b) counts within each field and clears on transition.
//    ETHER_TYPE -> PAYLOAD after its 2nd byte.
//  - len_cnt (11b) counts bytes from first dst byte. Saturates at 2047, no wrap.
//    pay_cnt (11b) counts payload bytes. Saturates.
//  - PAYLOAD: stay until rx_last.
//    Byte where len_cnt would exceed MAX_FRAME_BYTES -> DROP, error = err_giant.
//    Flag for that byte and later bytes is 0.
//  - DROP: all flags 0; exit to IDLE on rx_last.
//  - End of frame: rx_last & rx_valid in any non-IDLE state -> next cycle IDLE,
//    and frame_done=1 for one cycle with the status bits registered:
//    PAYLOAD: frame_ok=1 unless pay_cnt incl. last byte < MIN_PAYLOAD_FCS (err_runt=1).
//    PREAMBLE/DST/SRC/ETHER_TYPE: err_trunc=1 (also when rx_last is on the SFD
//      or on the final EtherType byte).
//    DROP with latched error: that error bit. DROP silent (entered from IDLE): no frame_done.
//  - rx_last in IDLE: byte ignored, no frame_done. A 0x55 there is a 1-byte frame
//    -> frame_done with err_trunc.
//  - Exactly one status bit is high when frame_done=1. Status bits are 0 otherwise.
//  - Reset (async, any time): state IDLE, all counters 0, frame_done and status 0,
//    latched error cleared. Flags 0 until valid bytes arrive.
//    A frame interrupted by reset is discarded: its tail enters DROP silently.
// STRUCTURE
//  - Shared package eth_pkg: state enum eth_rx_state_e; PREAMBLE_BYTE=8'h55,
//    SFD_BYTE=8'hD5, MAC_BYTES=6, ETHER_TYPE_BYTES=2, err-code enum for the latched error.
//  - Single module. No sub-module; counters and FSM inline.
// TESTING
//  - 7x55,D5, 6 dst, 6 src, 08 00, 46 payload + 4 FCS, rx_last on FCS
//      -> flags 8/6/6/2/50 bytes; frame_done+frame_ok 1 cycle after last.
//  - Same frame, payload 45 bytes (pay_cnt=49) -> frame_done+err_runt, frame_ok=0.
//  - 55,55,AA,... rx_last on byte 20 -> DROP after AA; frame_done+err_preamble
//      on cycle after byte 20; no flags from AA on.
//  - 8x55 (MAX=7) -> DROP on 8th byte; err_preamble at end. rx_last on 2nd EtherType
//      byte -> err_trunc.
//  - 1600-byte frame after SFD -> flags stop at byte 1518; err_giant at end.
//      rx_valid gaps mid-MAC: flag count unchanged.
//  - Assert rst during SRC_MAC, release, continue old tail to rx_last
//      -> no frame_done; next clean frame -> frame_ok.

Source files
------------

// File: rtl/eth_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : eth_pkg
// Brief  : Shared types and constants for the 1G MAC RX field sequencer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PREAMBLE   = 3'd1,
        ST_DST_MAC    = 3'd2,
        ST_SRC_MAC    = 3'd3,
        ST_ETHER_TYPE = 3'd4,
        ST_PAYLOAD    = 3'd5,
        ST_DROP       = 3'd6
    } eth_rx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_PREAMBLE = 2'd1,
        ERR_GIANT    = 2'd2
    } eth_err_e;

    typedef struct packed {
        logic ok;
        logic preamble;
        logic trunc;
        logic runt;
        logic giant;
    } eth_status_t;

    localparam logic [7:0] PREAMBLE_BYTE    = 8'h55;
    localparam logic [7:0] SFD_BYTE         = 8'hD5;
    localparam int         MAC_BYTES        = 6;
    localparam int         ETHER_TYPE_BYTES = 2;
    localparam int         CNT_W            = 11;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_fields_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : eth_fields_if
// Brief  : Per-byte field flags from the RX sequencer to field extractors.
// Rev    : 1.0
// ---------------------------------------------------------------------------
interface eth_fields_if;
    logic is_preamble_or_sfd;
    logic is_dst_mac;
    logic is_src_mac;
    logic is_ether_type;
    logic is_payload_or_fcs;

    modport master (
        output is_preamble_or_sfd,
        output is_dst_mac,
        output is_src_mac,
        output is_ether_type,
        output is_payload_or_fcs
    );

    modport slave (
        input is_preamble_or_sfd,
        input is_dst_mac,
        input is_src_mac,
        input is_ether_type,
        input is_payload_or_fcs
    );
endinterface
`default_nettype wire

// File: rtl/eth_field_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : eth_field_sequencer
// Brief  : Byte-wide RX field tracker with one end-of-frame status per frame.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module eth_field_sequencer
    import eth_pkg::*;
#(
    parameter int MAX_PREAMBLE_BYTES = 7,
    parameter int MIN_PAYLOAD_FCS    = 50,
    parameter int MAX_FRAME_BYTES    = 1518
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         rx_last,
    eth_fields_if.master fields,
    output logic         frame_done,
    output logic         frame_ok,
    output logic         err_preamble,
    output logic         err_trunc,
    output logic         err_runt,
    output logic         err_giant
);

    localparam int PRE_W = $clog2(MAX_PREAMBLE_BYTES + 1);

    eth_rx_state_e    r_state,   w_state;
    eth_err_e         r_err,     w_err;
    logic [PRE_W-1:0] r_pre_cnt, w_pre_cnt;
    logic [2:0]       r_fld_cnt, w_fld_cnt;
    logic [CNT_W-1:0] r_len_cnt, w_len_cnt;
    logic [CNT_W-1:0] r_pay_cnt, w_pay_cnt;
    logic             r_done,    w_done;
    eth_status_t      r_status,  w_status;

    logic             w_flag_pre, w_flag_dst, w_flag_src, w_flag_et, w_flag_pay;
    logic [CNT_W-1:0] w_len_inc, w_pay_inc;

    assign w_len_inc = sat_inc(r_len_cnt);
    assign w_pay_inc = sat_inc(r_pay_cnt);

    always_comb begin
        w_state    = r_state;
        w_err      = r_err;
        w_pre_cnt  = r_pre_cnt;
        w_fld_cnt  = r_fld_cnt;
        w_len_cnt  = r_len_cnt;
        w_pay_cnt  = r_pay_cnt;
        w_done     = 1'b0;
        w_status   = '0;
        w_flag_pre = 1'b0;
        w_flag_dst = 1'b0;
        w_flag_src = 1'b0;
        w_flag_et  = 1'b0;
        w_flag_pay = 1'b0;

        if (rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_data == PREAMBLE_BYTE) begin
                        w_flag_pre = 1'b1;
                        if (rx_last) begin
                            w_done         = 1'b1;
                            w_status.trunc = 1'b1;
                        end else begin
                            w_state   = ST_PREAMBLE;
                            w_pre_cnt = PRE_W'(1);
                        end
                    end else if (!rx_last) begin
                        // Mid-frame garbage (e.g. tail after reset): swallow silently.
                        w_state = ST_DROP;
                        w_err   = ERR_NONE;
                    end
                end

                ST_PREAMBLE: begin
                    if (rx_data == SFD_BYTE) begin
                        w_flag_pre = 1'b1;
                        if (rx_last) begin
                            w_state        = ST_IDLE;
                            w_done         = 1'b1;
                            w_status.trunc = 1'b1;
                        end else begin
                            w_state   = ST_DST_MAC;
                            w_fld_cnt = '0;
                            w_len_cnt = '0;
                            w_pay_cnt = '0;
                        end
                    end else if (rx_data == PREAMBLE_BYTE &&
                                 r_pre_cnt < PRE_W'(MAX_PREAMBLE_BYTES)) begin
                        w_flag_pre = 1'b1;
                        if (rx_last) begin
                            w_state        = ST_IDLE;
                            w_done         = 1'b1;
                            w_status.trunc = 1'b1;
                        end else begin
                            w_pre_cnt = r_pre_cnt + 1'b1;
                        end
                    end else begin
                        w_flag_pre = (rx_data == PREAMBLE_BYTE);
                        if (rx_last) begin
                            w_state           = ST_IDLE;
                            w_done            = 1'b1;
                            w_status.preamble = 1'b1;
                        end else begin
                            w_state = ST_DROP;
                            w_err   = ERR_PREAMBLE;
                        end
                    end
                end

                ST_DST_MAC, ST_SRC_MAC, ST_ETHER_TYPE: begin
                    w_flag_dst = (r_state == ST_DST_MAC);
                    w_flag_src = (r_state == ST_SRC_MAC);
                    w_flag_et  = (r_state == ST_ETHER_TYPE);
                    w_len_cnt  = w_len_inc;
                    if (rx_last) begin
                        w_state        = ST_IDLE;
                        w_done         = 1'b1;
                        w_status.trunc = 1'b1;
                    end else if (r_state == ST_ETHER_TYPE) begin
                        if (r_fld_cnt == 3'(ETHER_TYPE_BYTES - 1)) begin
                            w_state   = ST_PAYLOAD;
                            w_fld_cnt = '0;
                        end else begin
                            w_fld_cnt = r_fld_cnt + 1'b1;
                        end
                    end else if (r_fld_cnt == 3'(MAC_BYTES - 1)) begin
                        w_state   = (r_state == ST_DST_MAC) ? ST_SRC_MAC : ST_ETHER_TYPE;
                        w_fld_cnt = '0;
                    end else begin
                        w_fld_cnt = r_fld_cnt + 1'b1;
                    end
                end

                ST_PAYLOAD: begin
                    if (r_len_cnt >= CNT_W'(MAX_FRAME_BYTES)) begin
                        if (rx_last) begin
                            w_state        = ST_IDLE;
                            w_done         = 1'b1;
                            w_status.giant = 1'b1;
                        end else begin
                            w_state = ST_DROP;
                            w_err   = ERR_GIANT;
                        end
                    end else begin
                        w_flag_pay = 1'b1;
                        w_len_cnt  = w_len_inc;
                        w_pay_cnt  = w_pay_inc;
                        if (rx_last) begin
                            w_state = ST_IDLE;
                            w_done  = 1'b1;
                            if (w_pay_inc < CNT_W'(MIN_PAYLOAD_FCS)) begin
                                w_status.runt = 1'b1;
                            end else begin
                                w_status.ok = 1'b1;
                            end
                        end
                    end
                end

                ST_DROP: begin
                    if (rx_last) begin
                        w_state = ST_IDLE;
                        w_err   = ERR_NONE;
                        w_done  = (r_err != ERR_NONE);
                        w_status.preamble = (r_err == ERR_PREAMBLE);
                        w_status.giant    = (r_err == ERR_GIANT);
                    end
                end

                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_err     <= ERR_NONE;
            r_pre_cnt <= '0;
            r_fld_cnt <= '0;
            r_len_cnt <= '0;
            r_pay_cnt <= '0;
            r_done    <= 1'b0;
            r_status  <= '0;
        end else begin
            r_state   <= w_state;
            r_err     <= w_err;
            r_pre_cnt <= w_pre_cnt;
            r_fld_cnt <= w_fld_cnt;
            r_len_cnt <= w_len_cnt;
            r_pay_cnt <= w_pay_cnt;
            r_done    <= w_done;
            r_status  <= w_status;
        end
    end

    assign fields.is_preamble_or_sfd = w_flag_pre;
    assign fields.is_dst_mac         = w_flag_dst;
    assign fields.is_src_mac         = w_flag_src;
    assign fields.is_ether_type      = w_flag_et;
    assign fields.is_payload_or_fcs  = w_flag_pay;

    assign frame_done   = r_done;
    assign frame_ok     = r_status.ok;
    assign err_preamble = r_status.preamble;
    assign err_trunc    = r_status.trunc;
    assign err_runt     = r_status.runt;
    assign err_giant    = r_status.giant;

endmodule
`default_nettype wire

// File: tb/tb_eth_field_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_eth_field_sequencer
// Brief  : Directed + random frame bench against a frame-level reference model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_eth_field_sequencer;

    localparam int MAXP = 7;
    localparam int MINP = 50;
    localparam int MAXF = 1518;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_last = 1'b0;
    logic       frame_done, frame_ok, err_preamble, err_trunc, err_runt, err_giant;

    eth_fields_if fields();

    eth_field_sequencer #(
        .MAX_PREAMBLE_BYTES (MAXP),
        .MIN_PAYLOAD_FCS    (MINP),
        .MAX_FRAME_BYTES    (MAXF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_last      (rx_last),
        .fields       (fields),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .err_preamble (err_preamble),
        .err_trunc    (err_trunc),
        .err_runt     (err_runt),
        .err_giant    (err_giant)
    );

    always #5 clk = ~clk;

    logic [4:0] flag_vec;
    logic [5:0] status_vec;
    assign flag_vec   = {fields.is_preamble_or_sfd, fields.is_dst_mac, fields.is_src_mac,
                         fields.is_ether_type, fields.is_payload_or_fcs};
    assign status_vec = {frame_done, frame_ok, err_preamble, err_trunc, err_runt, err_giant};

    int tests = 0;
    int fails = 0;

    byte unsigned frm[$];
    byte unsigned tail[$];
    int           exp_fl[$];   // 0 none, 1 pre/sfd, 2 dst, 3 src, 4 ethertype, 5 payload
    int           exp_st;      // 0 no frame_done, 1 ok, 2 preamble, 3 trunc, 4 runt, 5 giant

    function automatic logic [4:0] onehot(input int c);
        case (c)
            1:       return 5'b10000;
            2:       return 5'b01000;
            3:       return 5'b00100;
            4:       return 5'b00010;
            5:       return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [5:0] exp_status(input int s);
        case (s)
            1:       return 6'b110000;
            2:       return 6'b101000;
            3:       return 6'b100100;
            4:       return 6'b100010;
            5:       return 6'b100001;
            default: return 6'b000000;
        endcase
    endfunction

    // Whole-frame view: classify by leading 0x55 run, SFD position and body length.
    function automatic void build_model();
        int n, p, m;
        n = frm.size();
        exp_fl.delete();
        for (int i = 0; i < n; i++) exp_fl.push_back(0);
        exp_st = 0;
        if (frm[0] != 8'h55) return;
        p = 0;
        while (p < n && frm[p] == 8'h55) p++;
        if (p > MAXP) begin
            for (int i = 0; i <= MAXP; i++) exp_fl[i] = 1;
            exp_st = 2;
            return;
        end
        for (int i = 0; i < p; i++) exp_fl[i] = 1;
        if (p == n) begin
            exp_st = 3;
            return;
        end
        if (frm[p] != 8'hD5) begin
            exp_st = 2;
            return;
        end
        exp_fl[p] = 1;
        m = n - p - 1;
        for (int off = 0; off < m; off++) begin
            if (off >= MAXF)    exp_fl[p+1+off] = 0;
            else if (off < 6)   exp_fl[p+1+off] = 2;
            else if (off < 12)  exp_fl[p+1+off] = 3;
            else if (off < 14)  exp_fl[p+1+off] = 4;
            else                exp_fl[p+1+off] = 5;
        end
        if (m <= 14)              exp_st = 3;
        else if (m > MAXF)        exp_st = 5;
        else if (m - 14 < MINP)   exp_st = 4;
        else                      exp_st = 1;
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push_pre(input int p);
        for (int i = 0; i < p; i++) frm.push_back(8'h55);
    endtask

    task automatic push_rand(input int k);
        for (int i = 0; i < k; i++) frm.push_back(8'($urandom));
    endtask

    task automatic push_good(input int p, input int k);
        frm.delete();
        push_pre(p);
        frm.push_back(8'hD5);
        push_rand(12);
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        push_rand(k);
    endtask

    // Called at posedge+1; sends frm[0..nsend-1], rx_last only on the true final byte.
    task automatic send_frame(input int nsend, input int gap_pct);
        build_model();
        for (int i = 0; i < nsend; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                rx_last  = 1'($urandom);
                @(negedge clk);
                check("gap_flags", {1'b0, flag_vec}, 6'd0);
                @(posedge clk); #1;
            end
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_last  = (i == frm.size() - 1);
            @(negedge clk);
            check("flags", {1'b0, flag_vec}, {1'b0, onehot(exp_fl[i])});
            @(posedge clk); #1;
            if (rx_last) check("status_end", status_vec, exp_status(exp_st));
            else         check("status_mid", status_vec, 6'd0);
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        if (nsend == frm.size()) begin
            @(posedge clk); #1;
            check("status_pulse", status_vec, 6'd0);
        end
    endtask

    task automatic gen_random(input int kind);
        int p, k;
        frm.delete();
        case (kind)
            0: push_good($urandom_range(1, 7), $urandom_range(50, 120));
            1: push_good($urandom_range(1, 7), $urandom_range(1, 49));
            2: begin
                push_good($urandom_range(1, 7), 0);
                k = $urandom_range(0, 15);
                if (k == 15) begin
                    frm.delete();
                    push_pre($urandom_range(1, 7));
                end else begin
                    while (frm.size() > 0 && frm[frm.size()-1] != 8'hD5 &&
                           (frm.size() - 1 - frm.size() + 14) >= 0 &&
                           frm.size() > 1 + k + 1 + 0 && frm.size() > 9 + k - 1) begin
                        void'(frm.pop_back());
                        if (frm.size() <= 1) break;
                    end
                end
            end
            3: begin
                p = $urandom_range(1, 7);
                push_pre(p);
                k = $urandom_range(0, 255);
                if (k == 8'h55 || k == 8'hD5) k = 8'hAA;
                frm.push_back(8'(k));
                push_rand($urandom_range(1, 10));
            end
            4: begin
                push_pre(8);
                push_rand($urandom_range(1, 10));
            end
            5: begin
                push_pre($urandom_range(1, 7));
                frm.push_back(8'hD5);
                push_rand($urandom_range(1520, 1600));
            end
            default: begin
                k = $urandom_range(0, 255);
                if (k == 8'h55) k = 8'h00;
                frm.push_back(8'(k));
                push_rand($urandom_range(0, 9));
            end
        endcase
    endtask

    initial begin
        int kind;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("reset_status", status_vec, 6'd0);
        check("reset_flags", {1'b0, flag_vec}, 6'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal frame: 7x55, SFD, 14 header bytes, 46 payload + 4 FCS
        push_good(7, 50);
        send_frame(frm.size(), 0);

        // Runt: 45 + 4
        push_good(7, 49);
        send_frame(frm.size(), 0);

        // Bad preamble byte, rx_last on byte 20
        frm.delete();
        push_pre(2);
        frm.push_back(8'hAA);
        push_rand(17);
        send_frame(frm.size(), 0);

        // Preamble too long
        frm.delete();
        push_pre(8);
        push_rand(5);
        send_frame(frm.size(), 0);

        // Truncated on the 2nd EtherType byte
        push_good(7, 0);
        send_frame(frm.size(), 0);

        // Truncated on the SFD
        frm.delete();
        push_pre(3);
        frm.push_back(8'hD5);
        send_frame(frm.size(), 0);

        // Giant frame with rx_valid gaps
        frm.delete();
        push_pre(7);
        frm.push_back(8'hD5);
        push_rand(1600);
        send_frame(frm.size(), 20);

        // Single 0x55 with rx_last, then a lone non-preamble byte with rx_last
        frm.delete();
        frm.push_back(8'h55);
        send_frame(1, 0);
        frm.delete();
        frm.push_back(8'h3C);
        send_frame(1, 0);

        // Reset during SRC_MAC, then finish the old tail, then a clean frame
        push_good(7, 50);
        send_frame(17, 0);
        #2 rst = 1'b1;
        #1 check("rst_mid_status", status_vec, 6'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tail = frm[17:$];
        tail[0] = 8'h11;
        frm = tail;
        send_frame(frm.size(), 10);
        push_good(7, 60);
        send_frame(frm.size(), 10);

        // Random frames
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 6);
            if (kind == 5 && $urandom_range(3) != 0) kind = 0;
            gen_random(kind);
            send_frame(frm.size(), $urandom_range(0, 30));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
